uart_tx_prescaled: RTL and testbench

UART transmitter for the UART system. Runs on the same oversampled clock as the receiver and times each serial bit with a per-bit edge counter of `prescale` clocks, so one clock and one prescale setting serve both directions.
Accepts a parallel word with a valid pulse and serialises it LSB-first as start, DATA_WIDTH data bits, optional parity and one stop bit. Reports `busy` to the upstream producer.

---
 rtl/uart_tx_prescaled.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_prescaled.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_prescaled.sv
// UART transmitter: start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Each serial bit lasts P clocks, where P is the prescale value latched when the word is accepted.
module uart_tx_prescaled #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            prescale,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            pre_q, pre_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  cnt_wrap_s;
  logic [3:0]            next_bit_s;

  // Out-of-range prescale values fall back to 8 clocks per bit.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if ((p >= 6'd4) && (p <= 6'd32)) begin
      return p;
    end else begin
      return 6'd8;
    end
  endfunction

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic bit_at(input logic [DATA_WIDTH-1:0] d, input logic [3:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b = b | (d[i] & (idx == 4'(i)));
    end
    return b;
  endfunction

  // Next-state logic; tx/busy are computed one edge ahead so the outputs come straight from flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    pre_d      = pre_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    cnt_wrap_s = (cnt_q == (pre_q - 6'd1));
    next_bit_s = bit_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = 6'd0;
        bit_d  = 4'd0;
        if (data_valid) begin
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          pre_d     = legal_prescale(prescale);
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_wrap_s) begin
          cnt_d   = 6'd0;
          bit_d   = 4'd0;
          state_d = S_DATA;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DATA: begin
        if (cnt_wrap_s) begin
          cnt_d = 6'd0;
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = parity_bit(data_q, par_typ_q);
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = next_bit_s;
            tx_d  = bit_at(data_q, next_bit_s);
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_PARITY: begin
        if (cnt_wrap_s) begin
          cnt_d   = 6'd0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_STOP: begin
        if (cnt_wrap_s) begin
          cnt_d   = 6'd0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        bit_d   = 4'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      bit_q     <= 4'd0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pre_q     <= 6'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      pre_q     <= pre_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Bench for uart_tx_prescaled: directed and random frames compared clock-by-clock
// against a bit-list model of the expected serial waveform.
module tb_uart_tx_prescaled;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    prescale = 6'd8;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          tx_out;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_prescaled #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the word is accepted at the following posedge.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps, input bit hold, input bit noise,
                            input logic [DW-1:0] noise_d);
    int   p;
    int   total;
    int   noise_at;
    logic bits[$];
    p = ((ps >= 6'd4) && (ps <= 6'd32)) ? int'(ps) : 8;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    total    = bits.size() * p;
    noise_at = (noise && !hold) ? int'($urandom_range(total - 3, 1)) : -1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      check_eq("tx_bit", {31'd0, tx_out}, {31'd0, bits[c / p]});
      check_eq("busy_frame", {31'd0, busy}, 32'd1);
      if (c == 0 && !hold) data_valid = 1'b0;
      if (c == noise_at) begin
        data_valid = 1'b1;
        p_data     = noise_d;
        par_en     = ~pe;
        par_typ    = ~pt;
        prescale   = 6'($urandom_range(63, 0));
      end
      if (noise_at >= 0 && c == noise_at + 1) data_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("idle_tx", {31'd0, tx_out}, 32'd1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

    // Basic frame, parity variants
    send_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0, 8'h00);
    send_frame(8'h07, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0, 8'h00);
    send_frame(8'h00, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0, 8'h00);

    // Request during a frame is dropped; inputs changed mid-frame have no effect
    send_frame(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1, 8'hFF);
    repeat (3) @(negedge clk);
    check_eq("no_queue_tx", {31'd0, tx_out}, 32'd1);
    check_eq("no_queue_busy", {31'd0, busy}, 32'd0);

    // Back-to-back with data_valid held
    for (int k = 0; k < 3; k++) send_frame(8'h55, 1'b0, 1'b0, 6'd8, 1'b1, 1'b0, 8'h00);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("b2b_end_busy", {31'd0, busy}, 32'd0);

    // Prescale boundaries and illegal values
    send_frame(8'h96, 1'b1, 1'b1, 6'd32, 1'b0, 1'b0, 8'h00);
    send_frame(8'h96, 1'b0, 1'b0, 6'd5, 1'b0, 1'b0, 8'h00);
    send_frame(8'h69, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0, 8'h00);
    send_frame(8'h69, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h81, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 8'h00);
    send_frame(8'h81, 1'b1, 1'b1, 6'd40, 1'b0, 1'b0, 8'h00);
    send_frame(8'h81, 1'b0, 1'b1, 6'd33, 1'b0, 1'b1, 8'h7E);

    // Asynchronous reset during DATA bit 3 of 0xC3 at prescale 8
    p_data = 8'hC3; par_en = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (34) @(negedge clk);
    check_eq("pre_rst_bit3", {31'd0, tx_out}, 32'd0);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_eq("after_rst_tx", {31'd0, tx_out}, 32'd1);
      check_eq("after_rst_busy", {31'd0, busy}, 32'd0);
    end

    // Random frames
    for (int k = 0; k < 25; k++) begin
      send_frame(DW'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(63, 0)),
                 1'b0, 1'($urandom), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
